// File: rtl/fifo_loader_pkg.sv
// Shared types and helpers for the skewed FIFO loader.
// Build option: FIFO_LOADER_AUTOCLR_EN clears the staging buffer on entry to DONE.
package fifo_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } loader_state_t;

    // Cycles needed so the last row's last word leaves the staging buffer.
    function automatic int stream_len(input int depth, input int num_fifo);
        return depth + num_fifo - 1;
    endfunction

endpackage

// File: rtl/loader_buf.sv
// Staging buffer: one host write port plus NUM_FIFO diagonally skewed read ports.
// A synchronous clear wipes the whole buffer; a write in the same cycle wins for its entry.
module loader_buf
    import fifo_loader_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int BITS     = 64,
    parameter int NUM_FIFO = 8,
    parameter int CW       = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [$clog2(NUM_FIFO)-1:0]        wr_row,
    input  logic [$clog2(DEPTH)-1:0]           wr_idx,
    input  logic [BITS-1:0]                    wr_data,
    input  logic                               clr,
    input  logic [CW-1:0]                      cnt,
    output logic [NUM_FIFO-1:0][BITS-1:0]      rd_data
);

    localparam int IW = $clog2(DEPTH);

    logic [BITS-1:0] mem [NUM_FIFO][DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_FIFO; r++)
                for (int k = 0; k < DEPTH; k++)
                    mem[r][k] <= '0;
        end else begin
            if (clr) begin
                for (int r = 0; r < NUM_FIFO; r++)
                    for (int k = 0; k < DEPTH; k++)
                        mem[r][k] <= '0;
            end
            // Out-of-range addresses only exist for non-power-of-2 sizes; they are dropped.
            if (wr_en && int'(wr_row) < NUM_FIFO && int'(wr_idx) < DEPTH)
                mem[wr_row][wr_idx] <= wr_data;
        end
    end

    // Row r lags row 0 by r cycles; the signed difference never wraps.
    for (genvar r = 0; r < NUM_FIFO; r++) begin : g_rd
        int diff;
        assign diff       = int'(cnt) - r;
        assign rd_data[r] = (diff >= 0 && diff < DEPTH) ? mem[r][diff[IW-1:0]] : '0;
    end

endmodule

// File: rtl/fifo_loader.sv
// Streams the staging buffer into the skew FIFO bank with one cycle of skew per row,
// then flushes zeros and pulses done. Build option: FIFO_LOADER_AUTOCLR_EN.
module fifo_loader
    import fifo_loader_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int BITS     = 64,
    parameter int NUM_FIFO = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    input  logic [$clog2(NUM_FIFO)-1:0]        wr_row,
    input  logic [$clog2(DEPTH)-1:0]           wr_idx,
    input  logic [BITS-1:0]                    wr_data,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [NUM_FIFO-1:0]                fifo_en,
    output logic [NUM_FIFO-1:0][BITS-1:0]      fifo_d
);

    localparam int CW        = $clog2(DEPTH + NUM_FIFO);
    localparam int STR_LAST  = stream_len(DEPTH, NUM_FIFO) - 1;
    localparam int FLSH_LAST = DEPTH - 1;

    loader_state_t                    state;
    logic [CW-1:0]                    cnt;
    logic                             buf_clr;
    logic [NUM_FIFO-1:0][BITS-1:0]    rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        cnt   <= '0;
                    end
                end
                STREAM: begin
                    if (cnt == CW'(STR_LAST)) begin
                        state <= FLUSH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FLUSH: begin
                    if (cnt == CW'(FLSH_LAST)) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign wr_ready = (state == IDLE) || (state == DONE);
    assign busy     = (state == STREAM) || (state == FLUSH);
    assign done     = (state == DONE);
    assign fifo_en  = busy ? '1 : '0;
    assign fifo_d   = (state == STREAM) ? rd_data : '0;

`ifdef FIFO_LOADER_AUTOCLR_EN
    // Clear lands on the FLUSH->DONE edge, so a DONE-cycle write survives.
    assign buf_clr = (state == FLUSH) && (cnt == CW'(FLSH_LAST));
`else
    assign buf_clr = 1'b0;
`endif

    loader_buf #(
        .DEPTH    (DEPTH),
        .BITS     (BITS),
        .NUM_FIFO (NUM_FIFO),
        .CW       (CW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_valid && wr_ready),
        .wr_row  (wr_row),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .clr     (buf_clr),
        .cnt     (cnt),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fifo_loader.sv
// Directed bench for fifo_loader: a staging-buffer model predicts every streamed cycle,
// expectations are queued at start and popped as the DUT produces output.
module tb_fifo_loader;

    localparam int DEPTH    = 8;
    localparam int BITS     = 64;
    localparam int NUM_FIFO = 8;
    localparam int NCYC     = (DEPTH + NUM_FIFO - 1) + DEPTH;  // start edge to done

    typedef struct {
        logic [NUM_FIFO-1:0]           en;
        logic [NUM_FIFO*BITS-1:0]      d;
        logic                          done;
        logic                          busy;
    } exp_t;

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic                            wr_valid;
    logic                            wr_ready;
    logic [$clog2(NUM_FIFO)-1:0]     wr_row;
    logic [$clog2(DEPTH)-1:0]        wr_idx;
    logic [BITS-1:0]                 wr_data;
    logic                            start;
    logic                            busy;
    logic                            done;
    logic [NUM_FIFO-1:0]             fifo_en;
    logic [NUM_FIFO-1:0][BITS-1:0]   fifo_d;

    logic [BITS-1:0] model [NUM_FIFO][DEPTH];
    exp_t            q [$];
    int              errors = 0;
    int              checks = 0;

    fifo_loader #(.DEPTH(DEPTH), .BITS(BITS), .NUM_FIFO(NUM_FIFO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_row   (wr_row),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .fifo_en  (fifo_en),
        .fifo_d   (fifo_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NUM_FIFO*BITS-1:0] obs,
                         input logic [NUM_FIFO*BITS-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < NUM_FIFO; r++)
            for (int k = 0; k < DEPTH; k++)
                model[r][k] = '0;
    endtask

    task automatic host_write(input int row, input int idx, input logic [BITS-1:0] data);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_row   = row[$clog2(NUM_FIFO)-1:0];
        wr_idx   = idx[$clog2(DEPTH)-1:0];
        wr_data  = data;
        model[row][idx] = data;
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    // Pulse start (optionally with a same-cycle write to row sw_row idx 0), optionally
    // try a start+write while streaming, and compare every cycle up to and including done.
    task automatic run_stream(input bit inject, input bit sw, input int sw_row,
                              input logic [BITS-1:0] sw_data);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        if (sw) begin
            wr_valid = 1'b1;
            wr_row   = sw_row[$clog2(NUM_FIFO)-1:0];
            wr_idx   = '0;
            wr_data  = sw_data;
            model[sw_row][0] = sw_data;
        end
        for (int i = 0; i <= NCYC; i++) begin
            e.d    = '0;
            e.en   = (i < NCYC) ? '1 : '0;
            e.busy = (i < NCYC);
            e.done = (i == NCYC);
            if (i < DEPTH + NUM_FIFO - 1) begin
                for (int r = 0; r < NUM_FIFO; r++)
                    if (i - r >= 0 && i - r < DEPTH)
                        e.d[r*BITS +: BITS] = model[r][i - r];
            end
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        wr_valid = 1'b0;
        for (int i = 0; i <= NCYC; i++) begin
            @(negedge clk);
            e = q.pop_front();
            check($sformatf("fifo_d c%0d", i), fifo_d, e.d);
            check($sformatf("fifo_en c%0d", i), {{(NUM_FIFO*BITS-NUM_FIFO){1'b0}}, fifo_en},
                  {{(NUM_FIFO*BITS-NUM_FIFO){1'b0}}, e.en});
            check($sformatf("done c%0d", i), {{(NUM_FIFO*BITS-1){1'b0}}, done},
                  {{(NUM_FIFO*BITS-1){1'b0}}, e.done});
            check($sformatf("busy c%0d", i), {{(NUM_FIFO*BITS-1){1'b0}}, busy},
                  {{(NUM_FIFO*BITS-1){1'b0}}, e.busy});
            if (inject && i == 3) begin
                start    = 1'b1;
                wr_valid = 1'b1;
                wr_row   = '0;
                wr_idx   = '0;
                wr_data  = 64'hFF;
                check("wr_ready busy", {{(NUM_FIFO*BITS-1){1'b0}}, wr_ready},
                      {(NUM_FIFO*BITS){1'b0}});
                @(posedge clk);
                #1;
                start    = 1'b0;
                wr_valid = 1'b0;
            end
        end
`ifdef FIFO_LOADER_AUTOCLR_EN
        clear_model();
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_row   = '0;
        wr_idx   = '0;
        wr_data  = '0;
        start    = 1'b0;
        clear_model();

        #22;
        check("rst wr_ready", {{(NUM_FIFO*BITS-1){1'b0}}, wr_ready}, {{(NUM_FIFO*BITS-1){1'b0}}, 1'b1});
        check("rst busy", {{(NUM_FIFO*BITS-1){1'b0}}, busy}, {(NUM_FIFO*BITS){1'b0}});
        check("rst done", {{(NUM_FIFO*BITS-1){1'b0}}, done}, {(NUM_FIFO*BITS){1'b0}});
        check("rst fifo_en", {{(NUM_FIFO*BITS-NUM_FIFO){1'b0}}, fifo_en}, {(NUM_FIFO*BITS){1'b0}});
        check("rst fifo_d", fifo_d, {(NUM_FIFO*BITS){1'b0}});
        @(negedge clk);
        rst_n = 1'b1;

        run_stream(1'b0, 1'b0, 0, '0);

        for (int k = 0; k < DEPTH; k++) begin
            host_write(0, k, 64'(k + 1));
            host_write(NUM_FIFO - 1, k, 64'(8'h71 + k));
        end
        run_stream(1'b1, 1'b0, 0, '0);
        run_stream(1'b0, 1'b0, 0, '0);

        run_stream(1'b0, 1'b1, 2, 64'hAB);

        // Reset at cnt=5 of a stream.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst fifo_en", {{(NUM_FIFO*BITS-NUM_FIFO){1'b0}}, fifo_en}, {(NUM_FIFO*BITS){1'b0}});
        check("midrst busy", {{(NUM_FIFO*BITS-1){1'b0}}, busy}, {(NUM_FIFO*BITS){1'b0}});
        check("midrst fifo_d", fifo_d, {(NUM_FIFO*BITS){1'b0}});
        check("midrst wr_ready", {{(NUM_FIFO*BITS-1){1'b0}}, wr_ready}, {{(NUM_FIFO*BITS-1){1'b0}}, 1'b1});
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            check($sformatf("postrst done c%0d", i), {{(NUM_FIFO*BITS-1){1'b0}}, done},
                  {(NUM_FIFO*BITS){1'b0}});
        end
        run_stream(1'b0, 1'b0, 0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
